mealy_code_decoder: RTL and testbench

Receive-side decoder for the 2-bit Mealy code stream produced by the team's mod-3 ones-counting Mealy machine. Given that machine's per-cycle output codes, it reconstructs the serial input bit stream, tracks the encoder's state, counts recovered ones, and detects illegal code transitions with automatic resynchronisation. It sits at the far end of the code link, in the same clock domain as the encoder.

---
 rtl/mealy_code_if.sv | 25 ++
 rtl/mealy_code_decoder.sv | 103 ++++++++++
 tb/tb_mealy_code_decoder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mealy_code_if.sv
// Code link between the mod-3 Mealy encoder side and the receive decoder.
// The master drives codes; the slave (decoder) returns recovered bits and status.
interface mealy_code_if #(
  parameter int CNT_W = 8
) ();
  logic             code_valid;
  logic [1:0]       code;
  logic             bit_valid;
  logic             bit_out;
  logic             err;
  logic             locked;
  logic [1:0]       state;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output code_valid, code,
    input  bit_valid, bit_out, err, locked, state, ones_cnt, err_cnt
  );

  modport slave (
    input  code_valid, code,
    output bit_valid, bit_out, err, locked, state, ones_cnt, err_cnt
  );
endinterface

// File: rtl/mealy_code_decoder.sv
// Receive-side decoder for the mod-3 ones-counting Mealy code stream: recovers
// input bits, tracks encoder state, counts ones and resyncs on illegal codes.
//
// state | meaning
// TRACK | locked to encoder, legal codes yield recovered bits
// HUNT  | after an illegal code, waiting for LOCK_N consecutive legal codes
module mealy_code_decoder #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 2
) (
  input logic        clk,
  input logic        rst,
  mealy_code_if.slave bus
);

  typedef enum logic {TRACK = 1'b0, HUNT = 1'b1} fsm_t;

  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  fsm_t             fsm, fsm_nxt;
  logic [1:0]       state_q, state_nxt;
  logic             bv_q, bv_nxt;
  logic             bo_q, bo_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] ones_q, ones_nxt;
  logic [CNT_W-1:0] errc_q, errc_nxt;
  logic [3:0]       lock_q, lock_nxt;
  logic [1:0]       succ;
  logic             legal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm     <= TRACK;
      state_q <= 2'd0;
      bv_q    <= 1'b0;
      bo_q    <= 1'b0;
      err_q   <= 1'b0;
      ones_q  <= '0;
      errc_q  <= '0;
      lock_q  <= 4'd0;
    end else begin
      fsm     <= fsm_nxt;
      state_q <= state_nxt;
      bv_q    <= bv_nxt;
      bo_q    <= bo_nxt;
      err_q   <= err_nxt;
      ones_q  <= ones_nxt;
      errc_q  <= errc_nxt;
      lock_q  <= lock_nxt;
    end
  end

  always_comb begin
    fsm_nxt   = fsm;
    state_nxt = state_q;
    bv_nxt    = 1'b0;
    bo_nxt    = bo_q;
    err_nxt   = 1'b0;
    ones_nxt  = ones_q;
    errc_nxt  = errc_q;
    lock_nxt  = lock_q;
    // State 3 folds back to 1: the encoder never returns to 0 once it leaves it
    succ  = (state_q == 2'd3) ? 2'd1 : state_q + 2'd1;
    legal = (bus.code == state_q) || (bus.code == succ);

    if (bus.code_valid) begin
      state_nxt = bus.code;
      if (!legal) begin
        err_nxt  = 1'b1;
        lock_nxt = 4'd0;
        fsm_nxt  = HUNT;
        if (errc_q != CNT_MAX) errc_nxt = errc_q + 1'b1;
      end else begin
        case (fsm)
          TRACK: begin
            bv_nxt = 1'b1;
            bo_nxt = (bus.code != state_q);
            if (bo_nxt) ones_nxt = ones_q + 1'b1;
          end
          HUNT: begin
            if (lock_q == LOCK_LAST) begin
              fsm_nxt  = TRACK;
              lock_nxt = 4'd0;
            end else begin
              lock_nxt = lock_q + 4'd1;
            end
          end
          default: fsm_nxt = TRACK;
        endcase
      end
    end
  end

  assign bus.bit_valid = bv_q;
  assign bus.bit_out   = bo_q;
  assign bus.err       = err_q;
  assign bus.locked    = (fsm == TRACK);
  assign bus.state     = state_q;
  assign bus.ones_cnt  = ones_q;
  assign bus.err_cnt   = errc_q;

endmodule

// File: tb/tb_mealy_code_decoder.sv
// Self-checking bench for mealy_code_decoder (CNT_W=4, LOCK_N=2): directed
// scenarios with literal expectations plus randomized traffic against a model.
module tb_mealy_code_decoder;
  localparam int CNT_W  = 4;
  localparam int LOCK_N = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mealy_code_if #(.CNT_W(CNT_W)) bus ();

  mealy_code_decoder #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: encoder state and counters as plain integers
  int m_state = 0, m_lock = 0, m_ones = 0, m_err = 0;
  bit m_hunt = 0, m_bv = 0, m_bo = 0, m_e = 0, m_init = 0;

  function automatic bit is_legal(input int s, input int c);
    return (c == s) || (c == (s % 3) + 1);
  endfunction

  always begin
    @(posedge clk);
    if (!rst) begin
      m_state = 0; m_lock = 0; m_ones = 0; m_err = 0;
      m_hunt = 0; m_bv = 0; m_bo = 0; m_e = 0; m_init = 1;
    end else begin
      m_bv = 0;
      m_e  = 0;
      if (bus.code_valid) begin
        if (!is_legal(m_state, int'(bus.code))) begin
          m_e = 1;
          m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
          m_hunt = 1;
          m_lock = 0;
        end else if (!m_hunt) begin
          m_bv = 1;
          m_bo = (int'(bus.code) != m_state);
          if (m_bo) m_ones = (m_ones + 1) % (CMAX + 1);
        end else begin
          m_lock++;
          if (m_lock == LOCK_N) begin
            m_hunt = 0;
            m_lock = 0;
          end
        end
        m_state = int'(bus.code);
      end
    end
    #1;
    if (m_init) begin
      chk("bit_valid", int'(bus.bit_valid), int'(m_bv));
      chk("err", int'(bus.err), int'(m_e));
      chk("locked", int'(bus.locked), int'(!m_hunt));
      chk("state", int'(bus.state), m_state);
      chk("ones_cnt", int'(bus.ones_cnt), m_ones);
      chk("err_cnt", int'(bus.err_cnt), m_err);
      if (m_bv) chk("bit_out", int'(bus.bit_out), int'(m_bo));
    end
  end

  task automatic step(input bit v, input int c, input bit r);
    @(negedge clk);
    rst = r;
    bus.code_valid = v;
    bus.code = 2'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
  endtask

  int seq [6] = '{0, 1, 1, 2, 3, 1};
  int exp_bits [6] = '{0, 1, 0, 1, 1, 1};

  initial begin
    int s;
    bus.code_valid = 1'b0;
    bus.code = 2'd0;
    do_reset();
    chk("rst_locked", int'(bus.locked), 1);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_ones", int'(bus.ones_cnt), 0);
    chk("rst_bv", int'(bus.bit_valid), 0);

    // Basic sequence, gapless
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i], 1'b1);
      chk("seq_bit", int'(bus.bit_out), exp_bits[i]);
      chk("seq_locked", int'(bus.locked), 1);
    end
    chk("seq_state", int'(bus.state), 1);
    chk("seq_ones", int'(bus.ones_cnt), 4);
    chk("seq_errcnt", int'(bus.err_cnt), 0);

    // Illegal code 3 from state 1, then relock
    step(1'b1, 3, 1'b1);
    chk("ill_err", int'(bus.err), 1);
    chk("ill_bv", int'(bus.bit_valid), 0);
    chk("ill_locked", int'(bus.locked), 0);
    chk("ill_errcnt", int'(bus.err_cnt), 1);
    chk("ill_state", int'(bus.state), 3);
    step(1'b1, 3, 1'b1);
    chk("hunt1_locked", int'(bus.locked), 0);
    chk("hunt1_bv", int'(bus.bit_valid), 0);
    step(1'b1, 1, 1'b1);
    chk("hunt2_locked", int'(bus.locked), 1);
    chk("hunt2_bv", int'(bus.bit_valid), 0);
    step(1'b1, 2, 1'b1);
    chk("relock_bv", int'(bus.bit_valid), 1);
    chk("relock_bit", int'(bus.bit_out), 1);

    // Same sequence with idle gaps of 1..3 cycles
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, seq[i], 1'b1);
      chk("gap_bit", int'(bus.bit_out), exp_bits[i]);
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        step(1'b0, int'($urandom_range(3, 0)), 1'b1);
        chk("gap_idle_bv", int'(bus.bit_valid), 0);
      end
    end
    chk("gap_ones", int'(bus.ones_cnt), 4);
    chk("gap_state", int'(bus.state), 1);

    // 17 ones wrap a 4-bit counter to 1; 20 illegal codes saturate at 15
    do_reset();
    s = 0;
    for (int i = 0; i < 17; i++) begin
      s = (s % 3) + 1;
      step(1'b1, s, 1'b1);
    end
    chk("wrap_ones", int'(bus.ones_cnt), 1);
    for (int i = 0; i < 20; i++) begin
      s = (s == 3) ? 2 : (s + 2) % 4;
      step(1'b1, s, 1'b1);
    end
    chk("sat_errcnt", int'(bus.err_cnt), 15);

    // Reset in HUNT with code_valid high
    do_reset();
    step(1'b1, 2, 1'b1);
    step(1'b1, 2, 1'b1);
    chk("hrst_pre_locked", int'(bus.locked), 0);
    step(1'b1, 3, 1'b0);
    chk("hrst_locked", int'(bus.locked), 1);
    chk("hrst_state", int'(bus.state), 0);
    chk("hrst_errcnt", int'(bus.err_cnt), 0);
    chk("hrst_err", int'(bus.err), 0);

    // Code 0 then 2 from state 0
    step(1'b1, 0, 1'b1);
    chk("z_bv", int'(bus.bit_valid), 1);
    chk("z_bit", int'(bus.bit_out), 0);
    step(1'b1, 2, 1'b1);
    chk("z2_err", int'(bus.err), 1);
    chk("z2_errcnt", int'(bus.err_cnt), 1);

    // Randomized traffic, mostly legal, occasional resets
    s = int'(bus.state);
    for (int i = 0; i < 600; i++) begin
      int c;
      if ($urandom_range(7, 0) == 0) c = int'($urandom_range(3, 0));
      else c = ($urandom_range(1, 0) == 1) ? (s % 3) + 1 : s;
      step($urandom_range(3, 0) != 0, c, $urandom_range(63, 0) != 0);
      s = int'(bus.state);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
